// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the audio mixer / sigma-delta DAC block.
package audio_mixer_pkg;

    typedef enum logic [2:0] {IDLE, LATCH, ACC, SAT, DCB} state_t;

    // Accumulator width that can never overflow for nch channels of in_w*vol_w products.
    function automatic int acc_w(input int in_w, input int vol_w, input int nch);
        return in_w + vol_w + $clog2(nch) + 1;
    endfunction

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: dout is the carry of a W-bit phase accumulator
// fed with an offset-binary input, so mean(dout) = din / 2^W.
module sigma_delta_dac #(
    parameter int W = 15
) (
    input  logic         clk_i,
    input  logic         res_n_i,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] sd_q, sd_d;
    logic         dout_q, dout_d;
    logic [W:0]   sum;

    // Accumulate and split the carry off as the output bit.
    always_comb begin
        sum    = {1'b0, sd_q} + {1'b0, din};
        sd_d   = sum[W-1:0];
        dout_d = sum[W];
    end

    // Modulator state.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sd_q   <= '0;
            dout_q <= 1'b0;
        end else begin
            sd_q   <= sd_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/audio_mixer_dac.sv
// N-channel time-multiplexed audio mixer with per-channel volume, saturation,
// overrun detection and a sigma-delta 1-bit DAC on the mixed sample.
// Optional DC-blocker after saturation: define AUDIO_MIXER_DCBLOCK_EN.
module audio_mixer_dac
    import audio_mixer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int IN_W  = 9,
    parameter int VOL_W = 4,
    parameter int OUT_W = 15
) (
    input  logic                    clk_i,
    input  logic                    res_n_i,
    input  logic                    sample_stb_i,
    input  logic [NCH*IN_W-1:0]     ch_data_i,
    input  logic [NCH-1:0]          ch_signed_i,
    input  logic [NCH*VOL_W-1:0]    ch_vol_i,
    input  logic                    mute_i,
    output logic signed [OUT_W-1:0] mix_o,
    output logic                    mix_valid_o,
    output logic                    clip_o,
    output logic                    overrun_o,
    output logic                    dac_o
);

    localparam int ACC_W = acc_w(IN_W, VOL_W, NCH);
    localparam int SH    = OUT_W - IN_W - VOL_W;
    localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NCH*IN_W-1:0]       dat_q, dat_d;
    logic [NCH-1:0]            sgn_q, sgn_d;
    logic [NCH*VOL_W-1:0]      vol_q, vol_d;
    logic signed [OUT_W-1:0]   mix_q, mix_d;
    logic                      vld_q, vld_d, clip_q, clip_d, ovr_q, ovr_d;

    logic [IN_W-1:0]           smp;
    logic [VOL_W-1:0]          vol;
    logic signed [IN_W-1:0]    s_k;
    logic signed [IN_W+VOL_W:0] p_k;
    logic signed [63:0]        v, sv;

`ifdef AUDIO_MIXER_DCBLOCK_EN
    logic signed [OUT_W-1:0]   x_q, x_d, x1_q, x1_d, y1_q, y1_d;
    logic                      sclip_q, sclip_d;
    logic signed [63:0]        y, ys;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: strobes are only accepted in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (sample_stb_i) state_d = LATCH;
            LATCH: state_d = ACC;
            ACC:   if (k_q == KW'(NCH - 1)) state_d = SAT;
`ifdef AUDIO_MIXER_DCBLOCK_EN
            SAT:   state_d = DCB;
`else
            SAT:   state_d = IDLE;
`endif
            DCB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs: snapshot, multiply-accumulate one channel per cycle, clamp.
    always_comb begin
        k_d    = k_q;
        acc_d  = acc_q;
        dat_d  = dat_q;
        sgn_d  = sgn_q;
        vol_d  = vol_q;
        mix_d  = mix_q;
        clip_d = clip_q;
        vld_d  = 1'b0;
        ovr_d  = sample_stb_i && (state_q != IDLE);

        smp = dat_q[k_q*IN_W +: IN_W];
        vol = vol_q[k_q*VOL_W +: VOL_W];
        // Offset binary to two's complement is an MSB flip.
        s_k = sgn_q[k_q] ? smp : {~smp[IN_W-1], smp[IN_W-2:0]};
        p_k = s_k * $signed({1'b0, vol});
        v   = 64'(acc_q) <<< SH;
        sv  = sat(v, OUT_W);

`ifdef AUDIO_MIXER_DCBLOCK_EN
        x_d     = x_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        sclip_d = sclip_q;
        y  = 64'(x_q) - 64'(x1_q) + 64'(y1_q) - (64'(y1_q) >>> 8);
        ys = sat(y, OUT_W);
`endif

        case (state_q)
            LATCH: begin
                dat_d = ch_data_i;
                sgn_d = ch_signed_i;
                vol_d = ch_vol_i;
                acc_d = '0;
                k_d   = '0;
            end
            ACC: begin
                acc_d = acc_q + ACC_W'(p_k);
                k_d   = k_q + 1'b1;
            end
`ifdef AUDIO_MIXER_DCBLOCK_EN
            SAT: begin
                x_d     = sv[OUT_W-1:0];
                sclip_d = (sv != v);
            end
            DCB: begin
                x1_d   = x_q;
                y1_d   = ys[OUT_W-1:0];
                mix_d  = mute_i ? '0 : ys[OUT_W-1:0];
                clip_d = !mute_i && (sclip_q || (ys != y));
                vld_d  = 1'b1;
            end
`else
            SAT: begin
                mix_d  = mute_i ? '0 : sv[OUT_W-1:0];
                clip_d = !mute_i && (sv != v);
                vld_d  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            k_q    <= '0;
            acc_q  <= '0;
            dat_q  <= '0;
            sgn_q  <= '0;
            vol_q  <= '0;
            mix_q  <= '0;
            clip_q <= 1'b0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            k_q    <= k_d;
            acc_q  <= acc_d;
            dat_q  <= dat_d;
            sgn_q  <= sgn_d;
            vol_q  <= vol_d;
            mix_q  <= mix_d;
            clip_q <= clip_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
        end
    end

`ifdef AUDIO_MIXER_DCBLOCK_EN
    // DC-blocker history, advanced only on produced samples.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            x_q     <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            sclip_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            sclip_q <= sclip_d;
        end
    end
`endif

    sigma_delta_dac #(.W(OUT_W)) u_dac (
        .clk_i   (clk_i),
        .res_n_i (res_n_i),
        .din     ({~mix_q[OUT_W-1], mix_q[OUT_W-2:0]}),
        .dout    (dac_o)
    );

    assign mix_o       = mix_q;
    assign mix_valid_o = vld_q;
    assign clip_o      = clip_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_audio_mixer_dac.sv
// Scoreboard bench for audio_mixer_dac (default build, NCH=4, IN_W=9, VOL_W=4, OUT_W=15).
module tb_audio_mixer_dac;

    localparam int NCH = 4, IN_W = 9, VOL_W = 4, OUT_W = 15;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    stb = 1'b0;
    logic [NCH*IN_W-1:0]     ch_data = '0;
    logic [NCH-1:0]          ch_sgn = '0;
    logic [NCH*VOL_W-1:0]    ch_vol = '0;
    logic                    mute = 1'b0;
    logic signed [OUT_W-1:0] mix_o;
    logic                    mix_valid_o, clip_o, overrun_o, dac_o;

    typedef struct {
        logic signed [OUT_W-1:0] mix;
        logic                    clip;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    audio_mixer_dac #(.NCH(NCH), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W)) dut (
        .clk_i        (clk),
        .res_n_i      (rst_n),
        .sample_stb_i (stb),
        .ch_data_i    (ch_data),
        .ch_signed_i  (ch_sgn),
        .ch_vol_i     (ch_vol),
        .mute_i       (mute),
        .mix_o        (mix_o),
        .mix_valid_o  (mix_valid_o),
        .clip_o       (clip_o),
        .overrun_o    (overrun_o),
        .dac_o        (dac_o)
    );

    task automatic set_ch(input int k, input logic [IN_W-1:0] d, input logic s, input logic [VOL_W-1:0] v);
        ch_data[k*IN_W +: IN_W]   = d;
        ch_sgn[k]                 = s;
        ch_vol[k*VOL_W +: VOL_W]  = v;
    endtask

    task automatic set_all(input logic [IN_W-1:0] d, input logic s, input logic [VOL_W-1:0] v);
        for (int k = 0; k < NCH; k++) set_ch(k, d, s, v);
    endtask

    // Strobe at edge 0, optional second strobe at edge `spacing` (0 = none) with new data.
    // Records overrun pulses and up to two valid samples within a bounded window.
    task automatic run_pair(input int spacing, input logic [NCH*IN_W-1:0] new_data,
                            output int ovr, output int nv, output int lat0, output int lat1,
                            output logic signed [OUT_W-1:0] m0, output logic signed [OUT_W-1:0] m1,
                            output logic c0, output logic c1);
        ovr = 0; nv = 0; lat0 = -1; lat1 = -1; m0 = '0; m1 = '0; c0 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1 stb = 1'b1;
        @(posedge clk); #1 stb = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            if (e == spacing) begin
                stb = 1'b1;
                ch_data = new_data;
            end
            @(posedge clk); #1;
            stb = 1'b0;
            if (overrun_o) ovr++;
            if (mix_valid_o) begin
                if (nv == 0) begin lat0 = e; m0 = mix_o; c0 = clip_o; end
                else         begin lat1 = e; m1 = mix_o; c1 = clip_o; end
                nv++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mix_o !== 15'sd0)     begin n_fail++; $display("FAIL rst_mix: got %0d want 0", mix_o); end
        n_cmp++; if (mix_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", mix_valid_o); end
        n_cmp++; if (clip_o !== 1'b0)      begin n_fail++; $display("FAIL rst_clip: got %b want 0", clip_o); end
        n_cmp++; if (overrun_o !== 1'b0)   begin n_fail++; $display("FAIL rst_ovr: got %b want 0", overrun_o); end
        n_cmp++; if (dac_o !== 1'b0)       begin n_fail++; $display("FAIL rst_dac: got %b want 0", dac_o); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (mix_o !== 15'sd0)     begin n_fail++; $display("FAIL post_rst_mix: got %0d want 0", mix_o); end
        n_cmp++; if (mix_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b want 0", mix_valid_o); end
        n_cmp++; if (dac_o !== 1'b0)       begin n_fail++; $display("FAIL post_rst_dac: got %b want 0", dac_o); end
    endtask

    task automatic test_single_channel;
        int ovr, nv, l0, l1; logic signed [OUT_W-1:0] m0, m1; logic c0, c1; exp_t e;
        set_all(9'h000, 1'b1, 4'd0);
        set_ch(0, 9'h0FF, 1'b1, 4'd15);
        sb.push_back('{15'sd15300, 1'b0});
        run_pair(0, ch_data, ovr, nv, l0, l1, m0, m1, c0, c1);
        e = sb.pop_front();
        n_cmp++; if (l0 !== NCH + 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", l0, NCH + 2); end
        n_cmp++; if (nv !== 1)       begin n_fail++; $display("FAIL single_nvalid: got %0d want 1", nv); end
        n_cmp++; if (m0 !== e.mix)   begin n_fail++; $display("FAIL single_mix: got %0d want %0d", m0, e.mix); end
        n_cmp++; if (c0 !== e.clip)  begin n_fail++; $display("FAIL single_clip: got %b want %b", c0, e.clip); end
        #3;
        n_cmp++; if (mix_o !== e.mix) begin n_fail++; $display("FAIL single_hold: got %0d want %0d", mix_o, e.mix); end
    endtask

    task automatic test_reset_mid_mix;
        int nvld; int ovr, nv, l0, l1; logic signed [OUT_W-1:0] m0, m1; logic c0, c1; exp_t e;
        nvld = 0;
        @(posedge clk); #1 stb = 1'b1;
        @(posedge clk); #1 stb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (mix_valid_o) nvld++;
        end
        n_cmp++; if (nvld !== 0)      begin n_fail++; $display("FAIL midrst_valid: got %0d pulses want 0", nvld); end
        n_cmp++; if (mix_o !== 15'sd0) begin n_fail++; $display("FAIL midrst_mix: got %0d want 0", mix_o); end
        // Block must be back in IDLE: a fresh strobe gives normal latency.
        set_all(9'h000, 1'b1, 4'd0);
        set_ch(2, 9'h1F0, 1'b1, 4'd7);     // -16 * 7 * 4 = -448
        sb.push_back('{-15'sd448, 1'b0});
        run_pair(0, ch_data, ovr, nv, l0, l1, m0, m1, c0, c1);
        e = sb.pop_front();
        n_cmp++; if (l0 !== NCH + 2) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", l0, NCH + 2); end
        n_cmp++; if (m0 !== e.mix)   begin n_fail++; $display("FAIL midrst_mix2: got %0d want %0d", m0, e.mix); end
    endtask

    task automatic test_unsigned_mute;
        int ovr, nv, l0, l1; logic signed [OUT_W-1:0] m0, m1; logic c0, c1; exp_t e;
        for (int t = 0; t < 3; t++) begin
            set_all(9'h100, 1'b0, 4'd15);
            if (t > 0) set_ch(0, 9'h1FF, 1'b0, 4'd15);
            mute = (t == 1);
            // Midscale offset binary is silence; 0x1FF is +255 -> 15300 unless muted.
            if (t == 2) sb.push_back('{15'sd15300, 1'b0});
            else        sb.push_back('{15'sd0, 1'b0});
            run_pair(0, ch_data, ovr, nv, l0, l1, m0, m1, c0, c1);
            e = sb.pop_front();
            n_cmp++; if (nv !== 1)      begin n_fail++; $display("FAIL unsg%0d_nvalid: got %0d want 1", t, nv); end
            n_cmp++; if (m0 !== e.mix)  begin n_fail++; $display("FAIL unsg%0d_mix: got %0d want %0d", t, m0, e.mix); end
            n_cmp++; if (c0 !== e.clip) begin n_fail++; $display("FAIL unsg%0d_clip: got %b want %b", t, c0, e.clip); end
        end
        mute = 1'b0;
    endtask

    task automatic test_saturation;
        int ovr, nv, l0, l1, ones; logic signed [OUT_W-1:0] m0, m1; logic c0, c1; exp_t e;
        logic signed [OUT_W-1:0] neg_full;
        neg_full = 15'h4000;
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: begin set_all(9'h0FF, 1'b1, 4'd15); sb.push_back('{15'sd16383, 1'b1}); end
                1: begin set_all(9'h100, 1'b1, 4'd15); sb.push_back('{neg_full, 1'b1}); end
                default: begin set_all(9'h100, 1'b1, 4'd15); mute = 1'b1; sb.push_back('{15'sd0, 1'b0}); end
            endcase
            run_pair(0, ch_data, ovr, nv, l0, l1, m0, m1, c0, c1);
            e = sb.pop_front();
            n_cmp++; if (m0 !== e.mix)  begin n_fail++; $display("FAIL sat%0d_mix: got %0d want %0d", t, m0, e.mix); end
            n_cmp++; if (c0 !== e.clip) begin n_fail++; $display("FAIL sat%0d_clip: got %b want %b", t, c0, e.clip); end
            if (t < 2) begin
                // Full-scale codes drive the bitstream to (nearly) all ones or all zeros.
                repeat (4) @(posedge clk);
                ones = 0;
                for (int i = 0; i < 512; i++) begin
                    @(posedge clk); #1;
                    if (dac_o) ones++;
                end
                if (t == 0) begin
                    n_cmp++; if (ones < 511) begin n_fail++; $display("FAIL dac_full_pos: got %0d ones want >=511", ones); end
                end else begin
                    n_cmp++; if (ones !== 0) begin n_fail++; $display("FAIL dac_full_neg: got %0d ones want 0", ones); end
                end
            end
        end
        mute = 1'b0;
    endtask

    task automatic test_overrun;
        int ovr, nv, l0, l1; logic signed [OUT_W-1:0] m0, m1; logic c0, c1; exp_t e;
        logic [NCH*IN_W-1:0] big;
        int sp [3];
        sp = '{3, NCH + 2, NCH + 3};
        for (int t = 0; t < 3; t++) begin
            set_all(9'h0FF, 1'b1, 4'd3);
            big = ch_data;
            set_all(9'h010, 1'b1, 4'd3);           // 16*3*4 ch = 192, <<2 = 768
            sb.push_back('{15'sd768, 1'b0});
            if (sp[t] == NCH + 3) sb.push_back('{15'sd12240, 1'b0});  // 255*3*4 <<2
            run_pair(sp[t], big, ovr, nv, l0, l1, m0, m1, c0, c1);
            e = sb.pop_front();
            n_cmp++; if (l0 !== NCH + 2) begin n_fail++; $display("FAIL ovr_sp%0d_lat: got %0d want %0d", sp[t], l0, NCH + 2); end
            n_cmp++; if (m0 !== e.mix)   begin n_fail++; $display("FAIL ovr_sp%0d_mix: got %0d want %0d", sp[t], m0, e.mix); end
            if (sp[t] == NCH + 3) begin
                e = sb.pop_front();
                n_cmp++; if (ovr !== 0)   begin n_fail++; $display("FAIL b2b_ovr: got %0d want 0", ovr); end
                n_cmp++; if (nv !== 2)    begin n_fail++; $display("FAIL b2b_nvalid: got %0d want 2", nv); end
                n_cmp++; if (l1 !== 2*NCH + 5) begin n_fail++; $display("FAIL b2b_lat: got %0d want %0d", l1, 2*NCH + 5); end
                n_cmp++; if (m1 !== e.mix) begin n_fail++; $display("FAIL b2b_mix: got %0d want %0d", m1, e.mix); end
            end else begin
                n_cmp++; if (ovr !== 1)   begin n_fail++; $display("FAIL ovr_sp%0d_pulses: got %0d want 1", sp[t], ovr); end
                n_cmp++; if (nv !== 1)    begin n_fail++; $display("FAIL ovr_sp%0d_nvalid: got %0d want 1", sp[t], nv); end
            end
        end
    endtask

    task automatic test_dac_midscale;
        int ovr, nv, l0, l1, ones; logic signed [OUT_W-1:0] m0, m1; logic c0, c1; exp_t e;
        set_all(9'h100, 1'b0, 4'd15);
        sb.push_back('{15'sd0, 1'b0});
        run_pair(0, ch_data, ovr, nv, l0, l1, m0, m1, c0, c1);
        e = sb.pop_front();
        n_cmp++; if (m0 !== e.mix) begin n_fail++; $display("FAIL dac_pre_mix: got %0d want %0d", m0, e.mix); end
        ones = 0;
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk); #1;
            if (dac_o) ones++;
        end
        n_cmp++; if (ones < 32767 || ones > 32769) begin n_fail++; $display("FAIL dac_mid: got %0d ones want 32768+-1", ones); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_reset_mid_mix();
        test_unsigned_mute();
        test_saturation();
        test_overrun();
        test_dac_midscale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_mixer_dac.md
Name: audio_mixer_dac

Overview:
- Parametrised N-channel audio mixer with a first-order sigma-delta 1-bit DAC output.
- Successor to the fixed two-source mix in the core top levels: machine audio plus tape sound into a fixed 15-bit DAC.
- Adds per-channel volume, signed or unsigned sources, time-multiplexed accumulation, saturation with clip flag, and a parallel PCM output for I2S/SPDIF.
- Sits in each core top level between the machine audio sources and the AUDIO_L/R pins.

Parameters:
- NCH, 4: number of input channels (1..16).
- IN_W, 9: sample width per channel.
- VOL_W, 4: volume width per channel; 0 = silent, 2^VOL_W-1 = full.
- OUT_W, 15: mixed output width; must satisfy OUT_W >= IN_W+VOL_W.

Ports:
- clk_i, in, 1: system clock.
- res_n_i, in, 1: reset.
- sample_stb_i, in, 1: one-cycle strobe; start a new mix.
- ch_data_i, in, NCH*IN_W: channel samples; channel k at bits [k*IN_W +: IN_W].
- ch_signed_i, in, NCH: 1 = two's complement, 0 = offset binary.
- ch_vol_i, in, NCH*VOL_W: per-channel volume.
- mute_i, in, 1: force mix output to zero.
- mix_o, out, OUT_W: signed mixed sample.
- mix_valid_o, out, 1: one-cycle pulse when mix_o updates.
- clip_o, out, 1: high with mix_valid_o if the sample saturated.
- overrun_o, out, 1: one-cycle pulse when a strobe is dropped.
- dac_o, out, 1: sigma-delta bitstream.

Behaviour:
- Clock and reset: one clock, clk_i. res_n_i is asynchronous, active-low.
- Reset state: mix_o=0, mix_valid_o=0, clip_o=0, overrun_o=0, dac_o=0, state IDLE, accumulators 0.
- Reset mid-mix: the mix is abandoned; no valid pulse is issued.
- State machine: IDLE -> LATCH -> ACC -> SAT -> IDLE.
- IDLE: sample_stb_i moves to LATCH.
- LATCH: snapshot ch_data_i, ch_signed_i and ch_vol_i into registers. Clear the accumulator and set channel index k=0.
- ACC: one channel per cycle.
  - s_k = signed ? data : data - 2^(IN_W-1), taken as IN_W-bit signed.
  - p_k = s_k * vol_k, unsigned volume.
  - acc += p_k.
  - ACC_W = IN_W+VOL_W+ceil(log2(NCH))+1, so the accumulator never overflows.
  - After k=NCH-1, go to SAT.
- SAT:
  - v = acc <<< (OUT_W-IN_W-VOL_W).
  - Clamp v to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; clip=1 if clamped.
  - mix_o <= mute_i ? 0 : v. clip_o is 0 when muted.
  - Pulse mix_valid_o, return to IDLE.
- Latency: strobe at cycle T gives mix_valid_o at T+NCH+2. Outputs hold between pulses.
- Strobe outside IDLE: dropped, overrun_o pulses the next cycle, and the current mix is unaffected.
- A strobe in the same cycle as SAT->IDLE is also dropped.
- Minimum strobe spacing: NCH+3 cycles.
- Inputs may change freely after LATCH.
- DAC:
  - u = mix_o with MSB inverted (offset binary).
  - Every cycle, {carry, sd} <= sd + u with sd OUT_W bits wide; dac_o <= carry.
  - The long-run mean of dac_o equals u/2^OUT_W.

Optional Feature:
- Macro: AUDIO_MIXER_DCBLOCK_EN.
- Defined: a DC-blocker stage follows SAT.
  - y = x - x1 + y1 - (y1 >>> 8), saturated to OUT_W.
  - x1/y1 registers are reset to 0 and updated only on valid samples.
  - Adds one cycle: mix_valid_o at T+NCH+3, minimum strobe spacing NCH+4.
  - clip_o covers both SAT and blocker clamping.
- Undefined: the stage is absent; latency is as above.

Decomposition:
- Package audio_mixer_pkg:
  - state enum (IDLE, LATCH, ACC, SAT, DCB).
  - ACC_W width function.
  - signed saturate function sat(value, width).
- Sub-module sigma_delta_dac (parameter W, ports clk_i, res_n_i, din, dout): the first-order modulator, reusable by other cores.

Test Plan:
- Reset checks:
  - After res_n_i release, all outputs are 0.
  - NCH=4, one strobe: mix_valid_o pulses exactly at T+6.
  - Drop res_n_i during ACC: no pulse; state is IDLE after release.
- Single channel: ch0 signed 9'h0FF (255), vol 15, others vol 0 -> mix_o = 255*15*4 = 15300, clip_o=0.
- Unsigned offset and mute:
  - All channels unsigned 9'h100, vol 15 -> mix_o = 0.
  - Same with mute_i=1 and ch0 = 9'h1FF -> mix_o = 0, clip_o=0.
- Saturation:
  - All four channels signed 9'h0FF, vol 15 -> mix_o = 16383, clip_o=1.
  - All 9'h100 (-256) -> mix_o = -16384, clip_o=1.
- Overrun: second strobe 3 cycles after the first -> overrun_o pulses once and the first result is unchanged.
- DAC and DC blocker:
  - mix_o = 0 (u = 16384) held for 2^16 cycles -> dac_o ones count = 32768 ±1.
  - With AUDIO_MIXER_DCBLOCK_EN, a constant 8000 input decays toward 0, with |mix_o| < 100 after 4000 samples.
